// File: rtl/ram_cmd_pkg.sv
// Shared types for the RAM command interface: opcodes carried in din[9:8],
// master FSM states and default widths.
package ram_cmd_pkg;

  localparam int unsigned DefAddrW   = 8;
  localparam int unsigned DefDataW   = 8;
  localparam int unsigned DefTimeout = 4;
  localparam int unsigned CntW       = 4;

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD      = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    StIdle,
    StWrAddr,
    StWrData,
    StRdAddr,
    StRdCmd,
    StRdWait,
    StResp
  } state_e;

endpackage

// File: rtl/ram_cmd_master.sv
// Turns read/write requests into the din/rx_valid command sequence for the RAM
// slave and returns read data, a write acknowledge or a read-timeout error.
module ram_cmd_master
  import ram_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned TIMEOUT    = DefTimeout,
  parameter int unsigned ADDR_CACHE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W+1:0] din,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] dout,
  input  logic              tx_valid
);

  state_e              r_state, w_state_d;
  logic [ADDR_W-1:0]   r_addr, w_addr_d;
  logic [DATA_W-1:0]   r_wdata, w_wdata_d;
  logic                r_write, w_write_d;
  logic [CntW-1:0]     r_cnt, w_cnt_d;
  logic                r_wc_vld, w_wc_vld_d;
  logic [ADDR_W-1:0]   r_wc_addr, w_wc_addr_d;
  logic                r_rc_vld, w_rc_vld_d;
  logic [ADDR_W-1:0]   r_rc_addr, w_rc_addr_d;

  logic [ADDR_W+1:0]   r_din, w_din_d;
  logic                r_rx_valid, w_rx_valid_d;
  logic                r_req_ready, w_req_ready_d;
  logic                r_rsp_valid, w_rsp_valid_d;
  logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_d;
  logic                r_rsp_err, w_rsp_err_d;

  logic                w_wr_hit, w_rd_hit;

  assign w_wr_hit = (ADDR_CACHE != 0) && r_wc_vld && (r_wc_addr == req_addr);
  assign w_rd_hit = (ADDR_CACHE != 0) && r_rc_vld && (r_rc_addr == req_addr);

  always_comb begin
    w_state_d     = r_state;
    w_addr_d      = r_addr;
    w_wdata_d     = r_wdata;
    w_write_d     = r_write;
    w_cnt_d       = r_cnt;
    w_wc_vld_d    = r_wc_vld;
    w_wc_addr_d   = r_wc_addr;
    w_rc_vld_d    = r_rc_vld;
    w_rc_addr_d   = r_rc_addr;
    w_rsp_rdata_d = '0;
    w_rsp_err_d   = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_addr_d  = req_addr;
          w_wdata_d = req_wdata;
          w_write_d = req_write;
          if (req_write) w_state_d = w_wr_hit ? StWrData : StWrAddr;
          else           w_state_d = w_rd_hit ? StRdCmd : StRdAddr;
        end
      end
      StWrAddr: begin
        w_wc_vld_d  = 1'b1;
        w_wc_addr_d = r_addr;
        w_state_d   = StWrData;
      end
      StWrData: w_state_d = StResp;
      StRdAddr: begin
        w_rc_vld_d  = 1'b1;
        w_rc_addr_d = r_addr;
        w_state_d   = StRdCmd;
      end
      StRdCmd: begin
        w_cnt_d   = '0;
        w_state_d = StRdWait;
      end
      StRdWait: begin
        if (tx_valid) begin
          w_rsp_rdata_d = dout;
          w_state_d     = StResp;
        end else if (r_cnt == CntW'(TIMEOUT - 1)) begin
          w_rsp_err_d = 1'b1;
          w_state_d   = StResp;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase

    // Outputs are registered from the next state; din stays 0 without a command
    // because the RAM decodes opcode 11 even when rx_valid is low.
    w_din_d      = '0;
    w_rx_valid_d = 1'b0;
    unique case (w_state_d)
      StWrAddr: begin
        w_din_d      = {OP_WR_ADDR, w_addr_d};
        w_rx_valid_d = 1'b1;
      end
      StWrData: begin
        w_din_d      = {OP_WR_DATA, ADDR_W'(w_wdata_d)};
        w_rx_valid_d = 1'b1;
      end
      StRdAddr: begin
        w_din_d      = {OP_RD_ADDR, w_addr_d};
        w_rx_valid_d = 1'b1;
      end
      StRdCmd: begin
        w_din_d      = {OP_RD, {ADDR_W{1'b0}}};
        w_rx_valid_d = 1'b1;
      end
      default: ;
    endcase
    w_req_ready_d = (w_state_d == StIdle);
    w_rsp_valid_d = (w_state_d == StResp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_write     <= 1'b0;
      r_cnt       <= '0;
      r_wc_vld    <= 1'b0;
      r_wc_addr   <= '0;
      r_rc_vld    <= 1'b0;
      r_rc_addr   <= '0;
      r_din       <= '0;
      r_rx_valid  <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_addr      <= w_addr_d;
      r_wdata     <= w_wdata_d;
      r_write     <= w_write_d;
      r_cnt       <= w_cnt_d;
      r_wc_vld    <= w_wc_vld_d;
      r_wc_addr   <= w_wc_addr_d;
      r_rc_vld    <= w_rc_vld_d;
      r_rc_addr   <= w_rc_addr_d;
      r_din       <= w_din_d;
      r_rx_valid  <= w_rx_valid_d;
      r_req_ready <= w_req_ready_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_rsp_rdata <= w_rsp_rdata_d;
      r_rsp_err   <= w_rsp_err_d;
    end
  end

  assign din       = r_din;
  assign rx_valid  = r_rx_valid;
  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_ram_cmd_master.sv
// Directed bench for ram_cmd_master: a cached instance driving a small RAM
// slave model, plus an uncached instance used for the back-to-back write case.
module tb_ram_cmd_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_valid_nc, req_write;
  logic [7:0] req_addr, req_wdata;
  logic       req_ready, rsp_valid, rsp_err, rx_valid, tx_valid;
  logic [7:0] rsp_rdata, dout;
  logic [9:0] din;
  logic       req_ready_nc, rsp_valid_nc, rsp_err_nc, rx_valid_nc;
  logic [7:0] rsp_rdata_nc;
  logic [9:0] din_nc;
  logic       tx_valid_nc = 1'b0;
  logic [7:0] dout_nc = 8'h00;

  logic [7:0] mem [256];
  logic [7:0] ram_wa, ram_ra;
  logic       ram_en;
  logic [7:0] sb [256];
  bit         sb_vld [256];
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  ram_cmd_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4), .ADDR_CACHE(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .din(din), .rx_valid(rx_valid), .dout(dout), .tx_valid(tx_valid)
  );

  ram_cmd_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4), .ADDR_CACHE(0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_nc), .req_ready(req_ready_nc),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_nc), .rsp_rdata(rsp_rdata_nc), .rsp_err(rsp_err_nc),
    .din(din_nc), .rx_valid(rx_valid_nc), .dout(dout_nc), .tx_valid(tx_valid_nc)
  );

  // RAM slave: read data valid the cycle after the 11 command
  always @(posedge clk) begin
    tx_valid <= 1'b0;
    if (rx_valid && ram_en) begin
      case (din[9:8])
        2'b00: ram_wa <= din[7:0];
        2'b01: mem[ram_wa] <= din[7:0];
        2'b10: ram_ra <= din[7:0];
        default: begin
          tx_valid <= 1'b1;
          dout     <= mem[ram_ra];
        end
      endcase
    end
  end

  task automatic next_cycle();
    @(negedge clk);
    total++;
    if (!rx_valid && din !== 10'h000) begin
      bad++;
      $display("FAIL idle_din: din=%h with rx_valid=0, required 000", din);
    end
  endtask

  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d, input logic both);
    int n;
    n = 0;
    next_cycle();
    while (!req_ready && n < 20) begin
      next_cycle();
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL ready_wait: req_ready=%b after 20 cycles, required 1", req_ready);
    end
    req_write = w; req_addr = a; req_wdata = d;
    req_valid = 1'b1; req_valid_nc = both;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_valid_nc = 1'b0;
    if (w) begin
      sb[a] = d;
      sb_vld[a] = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ram_en = 1'b1;
    req_valid = 1'b0; req_valid_nc = 1'b0; req_write = 1'b0;
    req_addr = 8'h00; req_wdata = 8'h00;
    #12;
    total += 3;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_hs: ready=%b rsp_valid=%b, required 1 0", req_ready, rsp_valid);
    end
    if (din !== 10'h000 || rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_cmd: din=%h rx_valid=%b, required 000 0", din, rx_valid);
    end
    if (rsp_rdata !== 8'h00 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL rst_rsp: rdata=%h err=%b, required 00 0", rsp_rdata, rsp_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    issue(1'b1, 8'h3C, 8'hA5, 1'b0);
    next_cycle(); total++;
    if (din !== 10'h03C || rx_valid !== 1'b1) begin
      bad++; $display("FAIL wr_addr: din=%h rx=%b, required 03c 1", din, rx_valid);
    end
    next_cycle(); total++;
    if (din !== 10'h1A5 || rx_valid !== 1'b1) begin
      bad++; $display("FAIL wr_data: din=%h rx=%b, required 1a5 1", din, rx_valid);
    end
    next_cycle(); total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 8'h00 || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL wr_rsp: v=%b err=%b rdata=%h ready=%b, required 1 0 00 0",
               rsp_valid, rsp_err, rsp_rdata, req_ready);
    end
    next_cycle(); total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL wr_idle: v=%b ready=%b, required 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_read();
    issue(1'b0, 8'h3C, 8'h00, 1'b0);
    next_cycle(); total++;
    if (din !== 10'h23C || rx_valid !== 1'b1) begin
      bad++; $display("FAIL rd_addr: din=%h rx=%b, required 23c 1", din, rx_valid);
    end
    next_cycle(); total++;
    if (din !== 10'h300 || rx_valid !== 1'b1) begin
      bad++; $display("FAIL rd_cmd: din=%h rx=%b, required 300 1", din, rx_valid);
    end
    next_cycle(); total++;
    if (tx_valid !== 1'b1 || dout !== 8'hA5 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rd_wait: tx=%b dout=%h v=%b, required 1 a5 0", tx_valid, dout, rsp_valid);
    end
    next_cycle(); total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL rd_rsp: v=%b rdata=%h err=%b, required 1 a5 0", rsp_valid, rsp_rdata, rsp_err);
    end
    next_cycle(); total++;
    if (req_ready !== 1'b1 || rsp_rdata !== 8'h00) begin
      bad++; $display("FAIL rd_idle: ready=%b rdata=%h, required 1 00", req_ready, rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 8'h10, 8'h11, 1'b1);
    next_cycle(); total++;
    if (din !== 10'h010 || din_nc !== 10'h010) begin
      bad++; $display("FAIL b2b_first: din=%h din_nc=%h, required 010 010", din, din_nc);
    end
    repeat (2) next_cycle();
    issue(1'b1, 8'h10, 8'h22, 1'b1);
    next_cycle(); total++;
    if (din !== 10'h122 || rx_valid !== 1'b1 || din_nc !== 10'h010) begin
      bad++;
      $display("FAIL b2b_t1: din=%h rx=%b din_nc=%h, required 122 1 010", din, rx_valid, din_nc);
    end
    next_cycle(); total++;
    if (rsp_valid !== 1'b1 || din_nc !== 10'h122 || rsp_valid_nc !== 1'b0) begin
      bad++;
      $display("FAIL b2b_t2: v=%b din_nc=%h v_nc=%b, required 1 122 0",
               rsp_valid, din_nc, rsp_valid_nc);
    end
    next_cycle(); total++;
    if (rsp_valid_nc !== 1'b1 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_t3: v_nc=%b ready=%b v=%b, required 1 1 0",
               rsp_valid_nc, req_ready, rsp_valid);
    end
  endtask

  task automatic test_timeout();
    ram_en = 1'b0;
    issue(1'b0, 8'h55, 8'h00, 1'b0);
    next_cycle(); total++;
    if (din !== 10'h255) begin
      bad++; $display("FAIL to_addr: din=%h, required 255", din);
    end
    next_cycle(); total++;
    if (din !== 10'h300) begin
      bad++; $display("FAIL to_cmd: din=%h, required 300", din);
    end
    // TIMEOUT wait cycles with no tx_valid, then the error pulse
    for (int i = 0; i < 4; i++) begin
      next_cycle(); total++;
      if (rsp_valid !== 1'b0) begin
        bad++; $display("FAIL to_wait%0d: rsp_valid=%b, required 0", i, rsp_valid);
      end
    end
    next_cycle(); total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 8'h00) begin
      bad++;
      $display("FAIL to_rsp: v=%b err=%b rdata=%h, required 1 1 00", rsp_valid, rsp_err, rsp_rdata);
    end
    next_cycle(); total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL to_idle: ready=%b v=%b err=%b, required 1 0 0", req_ready, rsp_valid, rsp_err);
    end
    ram_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 8'h3C, 8'h00, 1'b0);
    next_cycle();
    next_cycle(); total++;
    if (din !== 10'h300) begin
      bad++; $display("FAIL mid_cmd: din=%h, required 300", din);
    end
    #2 rst_n = 1'b0;
    #1 total++;
    if (din !== 10'h000 || rx_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_rst: din=%h rx=%b ready=%b, required 000 0 1", din, rx_valid, req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle(); total++;
      if (rsp_valid !== 1'b0) begin
        bad++; $display("FAIL mid_norsp%0d: rsp_valid=%b, required 0", i, rsp_valid);
      end
    end
    rst_n = 1'b1;
    issue(1'b0, 8'h3C, 8'h00, 1'b0);
    next_cycle(); total++;
    if (din !== 10'h23C) begin
      bad++; $display("FAIL mid_readdr: din=%h, required 23c", din);
    end
    repeat (2) next_cycle();
    next_cycle(); total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5) begin
      bad++; $display("FAIL mid_reread: v=%b rdata=%h, required 1 a5", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, d, exp_d;
    logic       w, seen;
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom_range(0, 15));
      d = 8'($urandom);
      w = 1'($urandom_range(0, 1));
      if (!sb_vld[a]) w = 1'b1;
      exp_d = w ? 8'h00 : sb[a];
      issue(w, a, d, 1'b0);
      // fields changing while busy must not disturb the transaction
      req_addr = 8'($urandom); req_wdata = 8'($urandom); req_write = 1'($urandom);
      seen = 1'b0;
      for (int k = 0; k < 12 && !seen; k++) begin
        next_cycle();
        if (rsp_valid) seen = 1'b1;
      end
      total++;
      if (!seen) begin
        bad++; $display("FAIL rnd%0d_rsp: no rsp_valid within 12 cycles, required 1", i);
      end else if (rsp_rdata !== exp_d || rsp_err !== 1'b0) begin
        bad++;
        $display("FAIL rnd%0d_data: w=%b addr=%h rdata=%h err=%b, required %h 0",
                 i, w, a, rsp_rdata, rsp_err, exp_d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at 1 ms, required finish");
    $fatal(1);
  end

endmodule

// File: doc/ram_cmd_master.md
Name: ram_cmd_master

Overview:
- Initiator for the single-port RAM command interface. Converts high-level read/write requests into the 10-bit din/rx_valid command sequence the RAM slave decodes:
  - din[9:8]=00: set write address
  - din[9:8]=01: write data
  - din[9:8]=10: set read address
  - din[9:8]=11: read
- Captures dout on tx_valid and returns read data or a write acknowledge.
- Sits between the SPI/host-side controller and the RAM.

Parameters:
- ADDR_W, 8, RAM address width; also the din payload width.
- DATA_W, 8, RAM data width.
- TIMEOUT, 4, cycles to wait for tx_valid after a read command before flagging an error (range 1..15).
- ADDR_CACHE, 1, when 1, skip the address phase if the address equals the last address sent for that direction.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  master can accept a request.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  read timed out.
- din  out  ADDR_W+2  command word to the RAM.
- rx_valid  out  1  command valid to the RAM.
- dout  in  DATA_W  RAM read data.
- tx_valid  in  1  RAM read data valid.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - state=IDLE, req_ready=1, din=0, rx_valid=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Write-address and read-address cache valid flags cleared; timeout counter=0.
- Registered outputs: all outputs are registered. din/rx_valid reflect the current state.
- din when no command: whenever rx_valid=0, din=0. The RAM asserts tx_valid from din[9:8] regardless of rx_valid, so opcode 11 must never appear when no command is issued.
- Request acceptance: on req_valid & req_ready in IDLE, latch addr, wdata and write. req_ready is high only in IDLE.
- States and transitions:
  - IDLE: write with cache hit -> WR_DATA; write otherwise -> WR_ADDR. Read with cache hit -> RD_CMD; read otherwise -> RD_ADDR.
  - WR_ADDR: din={00,addr}, rx_valid=1. Update write cache (valid=1, addr). -> WR_DATA.
  - WR_DATA: din={01,wdata}, rx_valid=1. -> RESP with err=0, rdata=0.
  - RD_ADDR: din={10,addr}, rx_valid=1. Update read cache. -> RD_CMD.
  - RD_CMD: din={11,0}, rx_valid=1. Clear timeout counter. -> RD_WAIT.
  - RD_WAIT: rx_valid=0, din=0.
    - tx_valid=1: capture dout -> RESP with err=0.
    - Otherwise increment the counter; when counter==TIMEOUT-1 with no tx_valid -> RESP with err=1, rdata=0.
  - RESP: rsp_valid=1 for exactly one cycle. -> IDLE (req_ready=1 the following cycle).
- Latency, request accept at cycle T, no cache hit:
  - Write: din commands at T+1 and T+2; rsp_valid at T+3.
  - Read: commands at T+1 (10) and T+2 (11); tx_valid seen at T+3; rsp_valid at T+4.
  - A cache hit removes one cycle.
- Cache rules:
  - ADDR_CACHE=0: always emit the address phase.
  - The write and read caches are independent; the RAM holds separate Wr_Addr/Rd_Addr registers.
- Spurious tx_valid: ignored outside RD_WAIT.
- Reset mid-operation: returns to IDLE immediately, outputs go to reset values, caches are invalidated, and no response is generated for the aborted request.
- Request fields held stable: req_* changes while req_ready=0 are ignored.

Decomposition:
- Package ram_cmd_pkg:
  - opcode enum: OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD=2'b11.
  - state enum.
  - Default widths.
  - Shared with the RAM and the UVM env.
- No sub-module needed; a single FSM module holding the timeout counter and the caches.

Test Plan:
1. Reset, then write addr 0x3C data 0xA5 -> din=0x03C (rx_valid=1) at T+1, 0x1A5 at T+2; rsp_valid=1, rsp_err=0 at T+3; din=0 afterwards.
2. Read 0x3C with a RAM model -> din=0x23C then 0x300; tx_valid with dout=0xA5 at T+3; rsp_valid with rsp_rdata=0xA5 at T+4.
3. Back-to-back writes to 0x10 (data 0x11, then 0x22), ADDR_CACHE=1 -> second write emits only 0x122 with no address phase; with ADDR_CACHE=0 it emits 0x010 then 0x122.
4. Read with tx_valid tied 0, TIMEOUT=4 -> rsp_valid with rsp_err=1 and rsp_rdata=0 exactly 4 cycles after RD_CMD; req_ready=1 the next cycle.
5. rst_n asserted asynchronously during RD_CMD -> din=0, rx_valid=0, req_ready=1 immediately; no rsp_valid; next read of 0x3C re-emits 0x23C.
6. Random stream of 200 mixed requests vs. a scoreboard memory -> every read returns the last written data; rx_valid=0 implies din[9:8]!=11 (assertion).
